// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Bus command encoding matches the core's BUS_NONE / BUS_LOAD / BUS_STORE values.
package dmem_pkg;

   localparam logic [1:0]  BUS_NONE      = 2'h0;
   localparam logic [1:0]  BUS_LOAD      = 2'h1;
   localparam logic [1:0]  BUS_STORE     = 2'h2;

   localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP,
      DONE
   } dmem_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-store FIFO used by dmem_ctrl when DMEM_WBUF_EN is defined.
// Pushes while full and pops while empty are ignored.
module dmem_wbuf
   import dmem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  wbuf_entry_t push_entry,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output wbuf_entry_t head
);

   localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

   wbuf_entry_t   mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   // NOTE: sequential state uses <= so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: MEM-stage command to a valid/ready request with timeout abort.
// Defining DMEM_WBUF_EN adds a posted store buffer of WBUF_DEPTH entries.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
`ifdef DMEM_WBUF_EN
   ,
   parameter int WBUF_DEPTH     = 2
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  proc2Dmem_command,
   input  logic [31:0] proc2Dmem_addr,
   input  logic [31:0] proc2Dmem_data,
   output logic [31:0] mem2proc_data,
   output logic        dmem_stall,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        mem_err
);

   localparam int               CNT_W        = 10;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   dmem_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      data_q, data_d;
   logic             we_q, we_d;
   logic             err_q, err_d;
   logic             stall;
   logic             req_valid;
   logic             is_cmd;
   logic             misaligned;

   assign is_cmd     = (proc2Dmem_command != BUS_NONE);
   assign misaligned = (proc2Dmem_addr[1:0] != 2'b00);

`ifdef DMEM_WBUF_EN
   logic        drain_q, drain_d;
   logic        push, pop, wbuf_full, wbuf_empty, is_store;
   wbuf_entry_t in_entry, head;

   assign is_store = (proc2Dmem_command == BUS_STORE);
   assign in_entry = {proc2Dmem_addr, proc2Dmem_data};

   dmem_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (in_entry),
      .pop        (pop),
      .full       (wbuf_full),
      .empty      (wbuf_empty),
      .head       (head)
   );
`endif

   always_comb begin
      // NOTE: every signal gets a default first so no branch can infer a latch.
      state_d   = state_q;
      cnt_d     = '0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      data_d    = data_q;
      err_d     = err_q;
      stall     = 1'b0;
      req_valid = 1'b0;
`ifdef DMEM_WBUF_EN
      drain_d   = drain_q;
      push      = 1'b0;
      pop       = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef DMEM_WBUF_EN
            if (is_cmd && misaligned) begin
               stall   = 1'b1;
               we_d    = is_store;
               data_d  = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else if (is_store && !wbuf_full) begin
               push = 1'b1;
               if (!wbuf_empty) begin
                  {addr_d, wdata_d} = head;
                  we_d    = 1'b1;
                  pop     = 1'b1;
                  drain_d = 1'b1;
                  state_d = REQ;
               end
            end else if (!wbuf_empty) begin
               // Older posted stores go out first so a later load sees their data.
               stall   = is_cmd;
               {addr_d, wdata_d} = head;
               we_d    = 1'b1;
               pop     = 1'b1;
               drain_d = 1'b1;
               state_d = REQ;
            end else if (is_cmd) begin
               stall   = 1'b1;
               addr_d  = proc2Dmem_addr;
               wdata_d = proc2Dmem_data;
               we_d    = is_store;
               data_d  = '0;
               state_d = REQ;
            end
`else
            stall = is_cmd;
            if (is_cmd) begin
               addr_d  = proc2Dmem_addr;
               wdata_d = proc2Dmem_data;
               we_d    = (proc2Dmem_command == BUS_STORE);
               data_d  = '0;
               if (misaligned) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = REQ;
               end
            end
`endif
         end
         REQ: begin
            stall     = 1'b1;
            req_valid = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (mem_req_ready) begin
               state_d = we_q ? DONE : WAIT_RSP;
            end else if (cnt_q == TIMEOUT_LAST) begin
               data_d  = DMEM_ERR_DATA;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         WAIT_RSP: begin
            stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (mem_rsp_valid) begin
               data_d  = mem_rsp_rdata;
               state_d = DONE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               data_d  = DMEM_ERR_DATA;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef DMEM_WBUF_EN
      // A drain is invisible to the pipeline: it only stalls a waiting command and skips DONE.
      if (drain_q) begin
         if (state_q == REQ) stall = is_cmd;
         if (state_d == DONE) begin
            state_d = IDLE;
            drain_d = 1'b0;
         end
      end
`endif
      if (state_d != REQ && state_d != WAIT_RSP) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef DMEM_WBUF_EN
         drain_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         data_q  <= data_d;
         err_q   <= err_d;
`ifdef DMEM_WBUF_EN
         drain_q <= drain_d;
`endif
      end
   end

   assign dmem_stall    = stall;
   assign mem_req_valid = req_valid;
   assign mem_req_we    = req_valid & we_q;
   assign mem_req_addr  = req_valid ? addr_q  : '0;
   assign mem_req_wdata = req_valid ? wdata_q : '0;
   assign mem2proc_data = (state_q == DONE) ? data_q : '0;
   assign mem_err       = err_q;

endmodule
